// File: rtl/c_arb_pkg.sv
// Shared types and helpers for the C result SRAM read arbiter.
// Consumers share one read port; the arbiter holds a single read in flight.
package c_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NREQ_DEFAULT = 3;
    localparam int PTR_W        = ptr_width(NREQ_DEFAULT);

endpackage

// File: rtl/c_rd_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Grants the first set request at or after ptr, searching upward with wrap.
module rr_pick
    import c_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant_oh,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_req
);

    logic found;
    int   idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/c_rd_arbiter.sv
// Round-robin arbiter for the C result SRAM read port: one read outstanding,
// responses routed to their owner, tile release once every consumer is done.
module c_rd_arbiter
    import c_arb_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int ROW_W       = 3,
    parameter int COL_W       = 3,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   c_valid,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*ROW_W-1:0]  req_row,
    input  logic [NREQ*COL_W-1:0]  req_col,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    input  logic [NREQ-1:0]        done,
    output logic                   tile_release,
    output logic                   mem_en,
    output logic                   mem_re,
    output logic [ROW_W-1:0]       mem_row,
    output logic [COL_W-1:0]       mem_col,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   dbg_state,
    output logic [NREQ-1:0]        dbg_done_seen
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = (TIMEOUT_CYC <= 2) ? 1 : $clog2(TIMEOUT_CYC);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] g_idx;
    logic [CNT_W-1:0] tcnt;
    logic [NREQ-1:0]  done_seen;

    logic [NREQ-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;
    logic             grant;
    logic             release_now;
    logic             timed_out;
    logic [PTR_W-1:0] next_ptr;
    logic [ROW_W-1:0] sel_row;
    logic [COL_W-1:0] sel_col;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any_req   (any_req)
    );

    // Handshake: req_ready[i] is offered only in IDLE while the tile is
    // complete, and a request is taken when req_valid[i] && req_ready[i].
    // req_ready never rises without req_valid, so any ready bit is a transfer.
    assign grant     = !rst && (state == IDLE) && c_valid && any_req;
    assign req_ready = grant ? pick_oh : '0;

    assign release_now = (state == IDLE) && (&done_seen);
    assign timed_out   = (tcnt == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        sel_row  = req_row[int'(pick_idx)*ROW_W +: ROW_W];
        sel_col  = req_col[int'(pick_idx)*COL_W +: COL_W];
        next_ptr = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            g_idx        <= '0;
            tcnt         <= '0;
            done_seen    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            tile_release <= 1'b0;
            mem_en       <= 1'b0;
            mem_re       <= 1'b0;
            mem_row      <= '0;
            mem_col      <= '0;
        end else begin
            rsp_valid    <= '0;
            rsp_err      <= 1'b0;
            tile_release <= release_now;
            // Done bits landing in the release cycle survive the clear.
            done_seen    <= (release_now ? '0 : done_seen) | done;

            case (state)
                IDLE: begin
                    if (grant) begin
                        g_idx   <= pick_idx;
                        rr_ptr  <= next_ptr;
                        tcnt    <= '0;
                        mem_en  <= 1'b1;
                        mem_re  <= 1'b1;
                        mem_row <= sel_row;
                        mem_col <= sel_col;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    // Returned data wins over a timeout in the same cycle.
                    if (mem_rvalid || timed_out) begin
                        rsp_data  <= mem_rvalid ? mem_rdata : '0;
                        rsp_err   <= !mem_rvalid;
                        rsp_valid <= NREQ'(1) << g_idx;
                        mem_en    <= 1'b0;
                        mem_re    <= 1'b0;
                        mem_row   <= '0;
                        mem_col   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state     = state;
    assign dbg_done_seen = done_seen;

endmodule

// File: tb/tb_c_rd_arbiter.sv
// Bench for c_rd_arbiter: table vectors, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_c_rd_arbiter;

    localparam int N   = 3;
    localparam int RW  = 3;
    localparam int CW  = 3;
    localparam int DW  = 32;
    localparam int TO  = 16;
    localparam int RBW = N * RW;
    localparam int CBW = N * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_valid;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [RBW-1:0] req_row;
    logic [CBW-1:0] req_col;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [N-1:0]  done;
    logic          tile_release;
    logic          mem_en;
    logic          mem_re;
    logic [RW-1:0] mem_row;
    logic [CW-1:0] mem_col;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          dbg_state;
    logic [N-1:0]  dbg_done_seen;

    c_rd_arbiter #(
        .NREQ(N), .ROW_W(RW), .COL_W(CW), .DATA_W(DW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .c_valid(c_valid), .req_valid(req_valid),
        .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .done(done), .tile_release(tile_release), .mem_en(mem_en),
        .mem_re(mem_re), .mem_row(mem_row), .mem_col(mem_col),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .dbg_state(dbg_state), .dbg_done_seen(dbg_done_seen)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference model: one read in flight, owner and wait length tracked as
    // plain integers, next-priority requester kept as an integer.
    bit            m_busy;
    int            m_owner, m_wait, m_next;
    int            m_row, m_col;
    logic [N-1:0]  m_seen;
    logic [N-1:0]  e_rsp;
    logic [DW-1:0] e_data;
    bit            e_err, e_rel;
    logic [N-1:0]  pre_ready;

    function automatic logic [N-1:0] model_ready();
        if (rst || m_busy || !c_valid) return '0;
        for (int j = 0; j < N; j++) begin
            int i = (m_next + j) % N;
            if (req_valid[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic step();
        logic [N-1:0] er;
        #1;
        er = model_ready();
        pre_ready = req_ready;
        chk("req_ready", req_ready, er);
        if (rst) begin
            m_busy = 0; m_next = 0; m_seen = '0;
            e_rsp = '0; e_err = 0; e_rel = 0; e_data = '0;
        end else begin
            e_rsp = '0; e_err = 0; e_rel = 0;
            if (!m_busy && m_seen == '1) begin
                e_rel  = 1;
                m_seen = '0;
            end
            m_seen = m_seen | done;
            if (m_busy) begin
                m_wait++;
                if (mem_rvalid || m_wait == TO) begin
                    e_rsp  = N'(1) << m_owner;
                    e_data = mem_rvalid ? mem_rdata : '0;
                    e_err  = !mem_rvalid;
                    m_busy = 0;
                end
            end else if (er != '0) begin
                for (int i = 0; i < N; i++) if (er[i]) m_owner = i;
                m_busy = 1;
                m_wait = 0;
                m_row  = int'(req_row[m_owner*RW +: RW]);
                m_col  = int'(req_col[m_owner*CW +: CW]);
                m_next = (m_owner + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("mem_en", mem_en, m_busy);
        chk("mem_re", mem_re, m_busy);
        if (m_busy) begin
            chk("mem_row", mem_row, m_row);
            chk("mem_col", mem_col, m_col);
        end
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("rsp_err", rsp_err, e_err);
        if (e_rsp != '0) chk("rsp_data", rsp_data, e_data);
        chk("tile_release", tile_release, e_rel);
        chk("done_seen", dbg_done_seen, m_seen);
    endtask

    // Driver tasks
    task automatic set_in(input logic cv, input logic [N-1:0] rv, input logic mv,
                          input logic [DW-1:0] rd, input logic [N-1:0] dn);
        c_valid = cv; req_valid = rv; mem_rvalid = mv; mem_rdata = rd; done = dn;
    endtask

    task automatic do_reset();
        set_in(0, '0, 0, '0, '0);
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    typedef struct {
        logic          cv;
        logic [N-1:0]  rv;
        logic          mv;
        logic [DW-1:0] rdata;
        logic [N-1:0]  exp_ready;
        logic          exp_en;
        logic [RW-1:0] exp_row;
        logic [CW-1:0] exp_col;
        logic [N-1:0]  exp_rsp;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl[$];
    int   fair_cnt[N];
    int   cyc, rel_cnt, gidx;

    initial begin
        rst = 1;
        req_row = {3'd3, 3'd2, 3'd1};
        req_col = {3'd6, 3'd5, 3'd4};
        do_reset();
        chk("reset_state", dbg_state, 1'b0);
        chk("reset_rsp_data", rsp_data, '0);

        // Gating for 10 cycles, first grant to 0, then a k=2 read for requester 1.
        for (int i = 0; i < 10; i++)
            tbl.push_back('{1'b0, 3'b111, 1'b0, 32'h0, 3'b000, 1'b0, 3'd0, 3'd0, 3'b000, 32'h0});
        tbl.push_back('{1'b1, 3'b111, 1'b0, 32'h0,        3'b001, 1'b1, 3'd1, 3'd4, 3'b000, 32'h0});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 32'h1234,     3'b000, 1'b0, 3'd0, 3'd0, 3'b001, 32'h1234});
        tbl.push_back('{1'b1, 3'b010, 1'b0, 32'h0,        3'b010, 1'b1, 3'd2, 3'd5, 3'b000, 32'h0});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 32'h0,        3'b000, 1'b1, 3'd2, 3'd5, 3'b000, 32'h0});
        tbl.push_back('{1'b1, 3'b000, 1'b1, 32'hDEADBEEF, 3'b000, 1'b0, 3'd0, 3'd0, 3'b010, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 3'b000, 1'b0, 32'h0,        3'b000, 1'b0, 3'd0, 3'd0, 3'b000, 32'h0});
        foreach (tbl[i]) begin
            set_in(tbl[i].cv, tbl[i].rv, tbl[i].mv, tbl[i].rdata, '0);
            step();
            chk("tbl_ready", pre_ready, tbl[i].exp_ready);
            chk("tbl_mem_en", mem_en, tbl[i].exp_en);
            if (tbl[i].exp_en) begin
                chk("tbl_row", mem_row, tbl[i].exp_row);
                chk("tbl_col", mem_col, tbl[i].exp_col);
            end
            chk("tbl_rsp_valid", rsp_valid, tbl[i].exp_rsp);
            if (tbl[i].exp_rsp != '0) begin
                chk("tbl_rsp_data", rsp_data, tbl[i].exp_data);
                chk("tbl_rsp_err", rsp_err, 1'b0);
            end
        end

        // Fairness: all valid, k=1.
        do_reset();
        foreach (fair_cnt[i]) fair_cnt[i] = 0;
        for (int n = 0; n < 6; n++) begin
            set_in(1, 3'b111, 0, '0, '0);
            step();
            chk("fair_order", pre_ready, N'(1) << (n % N));
            for (int i = 0; i < N; i++) if (pre_ready[i]) fair_cnt[i]++;
            set_in(1, 3'b111, 1, $urandom, '0);
            step();
        end
        for (int i = 0; i < N; i++) chk("fair_count", fair_cnt[i], 2);

        // Timeout: memory never answers.
        do_reset();
        set_in(1, 3'b100, 0, '0, '0);
        step();
        chk("to_mem_en", mem_en, 1'b1);
        set_in(1, 3'b000, 0, '0, '0);
        cyc = 0;
        while (cyc < 40) begin
            step();
            cyc++;
            if (rsp_valid != '0) break;
        end
        chk("to_latency", cyc, TO);
        chk("to_rsp_valid", rsp_valid, 3'b100);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_data", rsp_data, '0);

        // Release: done pulses 0, 2, 1 while a read waits.
        do_reset();
        rel_cnt = 0;
        set_in(1, 3'b001, 0, '0, '0);
        step();
        for (int i = 0; i < 7; i++) begin
            set_in(1, 3'b000, 0, '0, (i == 0) ? 3'b001 : (i == 2) ? 3'b100 : (i == 4) ? 3'b010 : 3'b000);
            step();
            rel_cnt += int'(tile_release);
        end
        set_in(1, 3'b000, 1, 32'hCAFE, '0);
        step();
        rel_cnt += int'(tile_release);
        chk("rel_rsp", rsp_valid, 3'b001);
        set_in(0, 3'b000, 0, '0, '0);
        step();
        rel_cnt += int'(tile_release);
        chk("rel_pulse", tile_release, 1'b1);
        chk("rel_seen_clear", dbg_done_seen, '0);
        step();
        rel_cnt += int'(tile_release);
        chk("rel_count", rel_cnt, 1);

        // Reset one cycle after a grant.
        do_reset();
        set_in(1, 3'b010, 0, '0, '0);
        step();
        rst = 1;
        set_in(1, 3'b000, 0, '0, '0);
        step();
        chk("rstw_mem_en", mem_en, 1'b0);
        chk("rstw_mem_row", mem_row, '0);
        chk("rstw_rsp_valid", rsp_valid, '0);
        chk("rstw_state", dbg_state, 1'b0);
        rst = 0;
        set_in(0, 3'b000, 1, 32'h5555, '0);
        step();
        chk("rstw_late_rvalid", rsp_valid, '0);
        set_in(0, 3'b000, 0, '0, '0);
        step();
        chk("rstw_quiet", rsp_valid, '0);

        // Randomized run against the model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            c_valid   = ($urandom_range(0, 3) != 0);
            req_valid = N'($urandom);
            req_row   = RBW'($urandom);
            req_col   = CBW'($urandom);
            mem_rvalid = ($urandom_range(0, (k < 250) ? 2 : 24) == 0);
            mem_rdata = $urandom;
            for (int i = 0; i < N; i++) done[i] = ($urandom_range(0, 7) == 0);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
